// File: rtl/segre_pkg.sv
// Shared core types and sizes; this slice carries the memory-arbiter additions.
package segre_pkg;

   localparam int ADDR_SIZE           = 32;
   localparam int WORD_SIZE           = 32;
   localparam int DCACHE_LANE_SIZE    = 128;
   localparam int MM_ARB_STARVE_LIMIT = 4;

   // Store access size forwarded to main memory.
   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } memop_data_type_e;

   // Main-memory arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } mm_arb_state_e;

   // Identity of the requester that owns the memory port.
   typedef enum logic [1:0] {
      ARB_IC = 2'b00,
      ARB_DC = 2'b01,
      ARB_WR = 2'b10
   } mm_arb_id_e;

endpackage

// File: rtl/segre_mem_arbiter_if.sv
// Cache-side and main-memory-side signals of the memory arbiter.
// slave: the arbiter's view. master: the caches plus main memory around it.
interface segre_mem_arbiter_if #(
   parameter int ADDR_SIZE = segre_pkg::ADDR_SIZE,
   parameter int WORD_SIZE = segre_pkg::WORD_SIZE,
   parameter int LANE_SIZE = segre_pkg::DCACHE_LANE_SIZE
);
   import segre_pkg::*;

   // Instruction cache refill
   logic                  ic_rd_req_i;
   logic [ADDR_SIZE-1:0]  ic_addr_i;
   logic                  ic_rdy_o;
   logic [LANE_SIZE-1:0]  ic_data_o;
   // Data cache refill
   logic                  dc_rd_req_i;
   logic [ADDR_SIZE-1:0]  dc_addr_i;
   logic                  dc_rdy_o;
   logic [LANE_SIZE-1:0]  dc_data_o;
   // Data cache store path
   logic                  dc_wr_req_i;
   logic [ADDR_SIZE-1:0]  dc_wr_addr_i;
   logic [WORD_SIZE-1:0]  dc_wr_data_i;
   memop_data_type_e      dc_wr_type_i;
   logic                  dc_wr_done_o;
   // Main memory
   logic                  mm_rd_o;
   logic                  mm_wr_o;
   logic [ADDR_SIZE-1:0]  mm_addr_o;
   logic [ADDR_SIZE-1:0]  mm_wr_addr_o;
   logic [WORD_SIZE-1:0]  mm_wr_data_o;
   memop_data_type_e      mm_wr_data_type_o;
   logic                  mm_data_rdy_i;
   logic [LANE_SIZE-1:0]  mm_rd_data_i;

   modport slave (
      input  ic_rd_req_i, ic_addr_i, dc_rd_req_i, dc_addr_i,
      input  dc_wr_req_i, dc_wr_addr_i, dc_wr_data_i, dc_wr_type_i,
      input  mm_data_rdy_i, mm_rd_data_i,
      output ic_rdy_o, ic_data_o, dc_rdy_o, dc_data_o, dc_wr_done_o,
      output mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_addr_o, mm_wr_data_o, mm_wr_data_type_o
   );

   modport master (
      output ic_rd_req_i, ic_addr_i, dc_rd_req_i, dc_addr_i,
      output dc_wr_req_i, dc_wr_addr_i, dc_wr_data_i, dc_wr_type_i,
      output mm_data_rdy_i, mm_rd_data_i,
      input  ic_rdy_o, ic_data_o, dc_rdy_o, dc_data_o, dc_wr_done_o,
      input  mm_rd_o, mm_wr_o, mm_addr_o, mm_wr_addr_o, mm_wr_data_o, mm_wr_data_type_o
   );

endinterface

// File: rtl/segre_mem_arbiter.sv
// Single main-memory port arbiter: I$ refill, D$ refill and D$ store requests.
// One transaction at a time; writes win unless reads have waited STARVE_LIMIT
// write grants, and the two reads alternate through a round-robin pointer.
module segre_mem_arbiter #(
   parameter int ADDR_SIZE    = segre_pkg::ADDR_SIZE,
   parameter int WORD_SIZE    = segre_pkg::WORD_SIZE,
   parameter int LANE_SIZE    = segre_pkg::DCACHE_LANE_SIZE,
   parameter int STARVE_LIMIT = segre_pkg::MM_ARB_STARVE_LIMIT
) (
   input  logic                clk_i,
   input  logic                rsn_i,
   segre_mem_arbiter_if.slave  arb_if
);
   import segre_pkg::*;

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   mm_arb_state_e         r_state, w_next_state;
   mm_arb_id_e            r_grant, r_rr, w_pick;
   logic [CNT_W-1:0]      r_starve_cnt;
   logic                  w_rd_pending, w_starve_hit, w_any_req, w_grant, w_done;

   logic                  r_mm_rd, r_mm_wr;
   logic [ADDR_SIZE-1:0]  r_mm_addr, r_mm_wr_addr;
   logic [WORD_SIZE-1:0]  r_mm_wr_data;
   memop_data_type_e      r_mm_wr_type;
   logic                  r_ic_rdy, r_dc_rdy, r_wr_done;
   logic [LANE_SIZE-1:0]  r_ic_data, r_dc_data;

   // Writes first; a starved read overrides; two reads go to the rr pointer.
   function automatic mm_arb_id_e pick_winner(input logic ic, input logic dc,
                                              input logic wr, input logic starve_hit,
                                              input mm_arb_id_e rr);
      if (wr && !starve_hit) return ARB_WR;
      if (ic && dc)          return rr;
      if (ic)                return ARB_IC;
      return ARB_DC;
   endfunction

   assign w_rd_pending = arb_if.ic_rd_req_i | arb_if.dc_rd_req_i;
   assign w_any_req    = w_rd_pending | arb_if.dc_wr_req_i;
   assign w_starve_hit = w_rd_pending && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
   assign w_pick       = pick_winner(arb_if.ic_rd_req_i, arb_if.dc_rd_req_i,
                                     arb_if.dc_wr_req_i, w_starve_hit, r_rr);

   // State register; an asserted reset drops any transaction in flight.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
      if (rsn_i) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next state plus the grant/complete strobes for the datapath.
   always_comb begin
      // NOTE: every output gets a default first, so no branch can infer a latch.
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: if (w_any_req) begin
            w_grant      = 1'b1;
            w_next_state = (w_pick == ARB_WR) ? WR : RD;
         end
         RD, WR: if (arb_if.mm_data_rdy_i) begin
            w_done       = 1'b1;
            w_next_state = RESP;
         end
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Latch winner, address, data and type at grant; hold the request until completion.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         // NOTE: address/data registers are reset as well because they drive outputs directly.
         r_grant      <= ARB_IC;
         r_mm_rd      <= 1'b0;
         r_mm_wr      <= 1'b0;
         r_mm_addr    <= '0;
         r_mm_wr_addr <= '0;
         r_mm_wr_data <= '0;
         r_mm_wr_type <= BYTE;
      end else if (w_grant) begin
         r_grant <= w_pick;
         if (w_pick == ARB_WR) begin
            r_mm_wr      <= 1'b1;
            r_mm_wr_addr <= arb_if.dc_wr_addr_i;
            r_mm_wr_data <= arb_if.dc_wr_data_i;
            r_mm_wr_type <= arb_if.dc_wr_type_i;
         end else begin
            r_mm_rd   <= 1'b1;
            r_mm_addr <= (w_pick == ARB_IC) ? arb_if.ic_addr_i : arb_if.dc_addr_i;
         end
      end else if (w_done) begin
         r_mm_rd <= 1'b0;
         r_mm_wr <= 1'b0;
      end
   end

   // Fairness history: round-robin pointer and consecutive-write counter.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         r_rr         <= ARB_IC;
         r_starve_cnt <= '0;
      end else if (w_grant) begin
         if (w_pick == ARB_WR) begin
            if (!w_rd_pending)
               r_starve_cnt <= '0;
            else if (r_starve_cnt != CNT_W'(STARVE_LIMIT))
               r_starve_cnt <= r_starve_cnt + 1'b1;
         end else begin
            r_starve_cnt <= '0;
            r_rr         <= (w_pick == ARB_IC) ? ARB_DC : ARB_IC;
         end
      end
   end

   // Completion: one-cycle pulse to the owner, read lane captured alongside.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         r_ic_rdy  <= 1'b0;
         r_dc_rdy  <= 1'b0;
         r_wr_done <= 1'b0;
         r_ic_data <= '0;
         r_dc_data <= '0;
      end else begin
         r_ic_rdy  <= 1'b0;
         r_dc_rdy  <= 1'b0;
         r_wr_done <= 1'b0;
         if (w_done) begin
            case (r_grant)
               ARB_IC: begin
                  r_ic_rdy  <= 1'b1;
                  r_ic_data <= arb_if.mm_rd_data_i;
               end
               ARB_DC: begin
                  r_dc_rdy  <= 1'b1;
                  r_dc_data <= arb_if.mm_rd_data_i;
               end
               default: r_wr_done <= 1'b1;
            endcase
         end
      end
   end

   assign arb_if.mm_rd_o           = r_mm_rd;
   assign arb_if.mm_wr_o           = r_mm_wr;
   assign arb_if.mm_addr_o         = r_mm_addr;
   assign arb_if.mm_wr_addr_o      = r_mm_wr_addr;
   assign arb_if.mm_wr_data_o      = r_mm_wr_data;
   assign arb_if.mm_wr_data_type_o = r_mm_wr_type;
   assign arb_if.ic_rdy_o          = r_ic_rdy;
   assign arb_if.ic_data_o         = r_ic_data;
   assign arb_if.dc_rdy_o          = r_dc_rdy;
   assign arb_if.dc_data_o         = r_dc_data;
   assign arb_if.dc_wr_done_o      = r_wr_done;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed scenarios plus a randomized run,
// each transaction's winner predicted by a request-level model of the rules.
module tb_segre_mem_arbiter;
   import segre_pkg::*;

   localparam int LIMIT = 4;
   localparam logic [127:0] LANE_AA = {16{8'hAA}};

   logic clk = 1'b0;
   logic rsn = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: who read last, and how many writes in a row jumped pending reads.
   int m_last_rd;   // 0 = IC, 1 = DC
   int m_starve;

   typedef struct {
      bit               timeout;
      int               kind;      // 0 read, 1 write
      logic [31:0]      addr;
      logic [31:0]      wdata;
      memop_data_type_e wtype;
      int               who;       // 0 IC, 1 DC, 2 WR, -1 no pulse, -2 several
      logic [127:0]     data;
      bit               both_hi;
      bit               hold_ok;
      bit               dropped;
      bit               pulse_ok;
   } obs_t;

   segre_mem_arbiter_if bus ();

   segre_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_i  (clk),
      .rsn_i  (rsn),
      .arb_if (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_last_rd = 1;
      m_starve  = 0;
   endtask

   // Winner of a grant given the request levels seen in IDLE.
   function automatic int model_pick(input bit ic, input bit dc, input bit wr);
      bit rd;
      int w;
      rd = ic | dc;
      if (wr && !(rd && m_starve >= LIMIT)) begin
         w = 2;
         m_starve = rd ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else begin
         w = (ic && dc) ? (1 - m_last_rd) : (ic ? 0 : 1);
         m_last_rd = w;
         m_starve  = 0;
      end
      return w;
   endfunction

   task automatic clear_inputs();
      bus.ic_rd_req_i   = 1'b0;  bus.ic_addr_i    = '0;
      bus.dc_rd_req_i   = 1'b0;  bus.dc_addr_i    = '0;
      bus.dc_wr_req_i   = 1'b0;  bus.dc_wr_addr_i = '0;
      bus.dc_wr_data_i  = '0;    bus.dc_wr_type_i = BYTE;
      bus.mm_data_rdy_i = 1'b0;  bus.mm_rd_data_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rsn = 1'b1;
      repeat (2) tick();
      rsn = 1'b0;
      model_reset();
   endtask

   // Acts as main memory for one transaction and records what the DUT did.
   // Returns at the negedge after the completion pulse, with the owner's request dropped.
   task automatic serve(input int lat, input logic [127:0] rdata, output obs_t o);
      int t;
      int np;
      o.timeout = 1'b0; o.kind = -1; o.addr = '0; o.wdata = '0; o.wtype = BYTE;
      o.who = -1; o.data = '0; o.both_hi = 1'b0; o.hold_ok = 1'b1;
      o.dropped = 1'b0; o.pulse_ok = 1'b1;
      t = 0;
      while (!(bus.mm_rd_o || bus.mm_wr_o) && t < 20) begin
         tick();
         t++;
      end
      if (t == 20) begin
         o.timeout = 1'b1;
         return;
      end
      o.kind    = bus.mm_wr_o ? 1 : 0;
      o.both_hi = bus.mm_rd_o & bus.mm_wr_o;
      o.addr    = bus.mm_wr_o ? bus.mm_wr_addr_o : bus.mm_addr_o;
      o.wdata   = bus.mm_wr_data_o;
      o.wtype   = bus.mm_wr_data_type_o;
      repeat (lat) begin
         tick();
         o.both_hi |= bus.mm_rd_o & bus.mm_wr_o;
         o.hold_ok &= (bus.mm_rd_o | bus.mm_wr_o) &
                      !(bus.ic_rdy_o | bus.dc_rdy_o | bus.dc_wr_done_o);
      end
      bus.mm_data_rdy_i = 1'b1;
      bus.mm_rd_data_i  = rdata;
      tick();
      bus.mm_data_rdy_i = 1'b0;
      bus.mm_rd_data_i  = {4{$urandom}};
      np = int'(bus.ic_rdy_o) + int'(bus.dc_rdy_o) + int'(bus.dc_wr_done_o);
      if (np > 1)               o.who = -2;
      else if (bus.ic_rdy_o)    o.who = 0;
      else if (bus.dc_rdy_o)    o.who = 1;
      else if (bus.dc_wr_done_o) o.who = 2;
      o.data    = bus.ic_rdy_o ? bus.ic_data_o : bus.dc_data_o;
      o.dropped = !(bus.mm_rd_o | bus.mm_wr_o);
      if (bus.ic_rdy_o)     bus.ic_rd_req_i = 1'b0;
      if (bus.dc_rdy_o)     bus.dc_rd_req_i = 1'b0;
      if (bus.dc_wr_done_o) bus.dc_wr_req_i = 1'b0;
      tick();
      o.pulse_ok = !(bus.ic_rdy_o | bus.dc_rdy_o | bus.dc_wr_done_o);
   endtask

   task automatic test_reset();
      obs_t o;
      clear_inputs();
      rsn = 1'b1;
      repeat (2) tick();
      n_checks++;
      if ({bus.mm_rd_o, bus.mm_wr_o, bus.ic_rdy_o, bus.dc_rdy_o, bus.dc_wr_done_o,
           bus.mm_addr_o, bus.mm_wr_addr_o, bus.mm_wr_data_o, bus.mm_wr_data_type_o,
           bus.ic_data_o, bus.dc_data_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: mm_rd=%b mm_wr=%b ic_data=%h got nonzero, required all 0",
                  bus.mm_rd_o, bus.mm_wr_o, bus.ic_data_o);
      end
      rsn = 1'b0;
      model_reset();
      bus.ic_rd_req_i = 1'b1;
      bus.ic_addr_i   = 32'h100;
      tick();
      n_checks++;
      if (bus.mm_rd_o !== 1'b1 || bus.mm_addr_o !== 32'h100) begin
         n_fail++;
         $display("FAIL reset_first_read: mm_rd=%b addr=%h, required 1 / 00000100",
                  bus.mm_rd_o, bus.mm_addr_o);
      end
      void'(model_pick(1'b1, 1'b0, 1'b0));
      serve(0, LANE_AA, o);
      n_checks++;
      if (o.timeout || o.who !== 0 || o.data !== LANE_AA) begin
         n_fail++;
         $display("FAIL reset_ic_refill: who=%0d data=%h timeout=%b, required 0 / %h",
                  o.who, o.data, o.timeout, LANE_AA);
      end
   endtask

   task automatic test_round_robin();
      obs_t o;
      int   exp;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.ic_rd_req_i = 1'b1;  bus.ic_addr_i = 32'h1000 + 32'(k);
         bus.dc_rd_req_i = 1'b1;  bus.dc_addr_i = 32'h2000 + 32'(k);
         exp = model_pick(1'b1, 1'b1, 1'b0);
         serve(k % 2, {4{32'(k)}}, o);
         n_checks++;
         if (o.timeout || o.who !== exp || o.kind !== 0 ||
             o.addr !== (exp == 0 ? 32'h1000 : 32'h2000) + 32'(k)) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: who=%0d kind=%0d addr=%h, required who=%0d read",
                     k, o.who, o.kind, o.addr, exp);
         end
      end
      clear_inputs();
   endtask

   task automatic test_starvation();
      obs_t o;
      int   exp;
      do_reset();
      bus.ic_rd_req_i = 1'b1;
      bus.ic_addr_i   = 32'h3000;
      for (int k = 0; k < 6; k++) begin
         if (!bus.dc_wr_req_i) begin
            bus.dc_wr_req_i  = 1'b1;
            bus.dc_wr_addr_i = 32'h4000 + 32'(k * 4);
            bus.dc_wr_data_i = $urandom;
            bus.dc_wr_type_i = WORD;
         end
         exp = model_pick(bus.ic_rd_req_i, 1'b0, 1'b1);
         serve(1, '1, o);
         n_checks++;
         if (o.timeout || o.who !== exp) begin
            n_fail++;
            $display("FAIL starve_order_%0d: who=%0d, required %0d", k, o.who, exp);
         end
      end
      clear_inputs();
   endtask

   task automatic test_simultaneous();
      obs_t o;
      int   exp;
      do_reset();
      bus.ic_rd_req_i  = 1'b1;  bus.ic_addr_i    = 32'h5000;
      bus.dc_rd_req_i  = 1'b1;  bus.dc_addr_i    = 32'h6000;
      bus.dc_wr_req_i  = 1'b1;  bus.dc_wr_addr_i = 32'h7004;
      bus.dc_wr_data_i = 32'hCAFE_F00D;
      bus.dc_wr_type_i = HALF;
      exp = model_pick(1'b1, 1'b1, 1'b1);
      serve(0, '0, o);
      n_checks++;
      if (o.timeout || o.who !== exp || o.kind !== 1 || o.addr !== 32'h7004) begin
         n_fail++;
         $display("FAIL simul_winner: who=%0d kind=%0d addr=%h, required %0d write 00007004",
                  o.who, o.kind, o.addr, exp);
      end
      n_checks++;
      if (o.wtype !== HALF || o.wdata !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL simul_type: type=%0d data=%h, required %0d cafef00d",
                  o.wtype, o.wdata, HALF);
      end
      n_checks++;
      if (o.pulse_ok !== 1'b1 || o.both_hi !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_done_once: pulse_ok=%b both_hi=%b, required 1 / 0",
                  o.pulse_ok, o.both_hi);
      end
      for (int k = 0; k < 2; k++) begin
         exp = model_pick(bus.ic_rd_req_i, bus.dc_rd_req_i, 1'b0);
         serve(0, {4{32'(k + 7)}}, o);
         n_checks++;
         if (o.timeout || o.who !== exp || o.data !== {4{32'(k + 7)}}) begin
            n_fail++;
            $display("FAIL simul_read_%0d: who=%0d data=%h, required %0d",
                     k, o.who, o.data, exp);
         end
      end
      clear_inputs();
   endtask

   task automatic test_stability();
      obs_t o;
      do_reset();
      bus.ic_rd_req_i = 1'b1;
      bus.ic_addr_i   = 32'h0000_ABC0;
      tick();
      bus.ic_addr_i = 32'h0000_DEF0;
      tick();
      n_checks++;
      if (bus.mm_rd_o !== 1'b1 || bus.mm_addr_o !== 32'h0000_ABC0) begin
         n_fail++;
         $display("FAIL stable_addr: mm_rd=%b addr=%h, required 1 / 0000abc0",
                  bus.mm_rd_o, bus.mm_addr_o);
      end
      void'(model_pick(1'b1, 1'b0, 1'b0));
      serve(0, LANE_AA, o);
      n_checks++;
      if (o.timeout || o.who !== 0 || o.dropped !== 1'b1) begin
         n_fail++;
         $display("FAIL stable_complete: who=%0d dropped=%b, required 0 / 1", o.who, o.dropped);
      end
      bus.mm_data_rdy_i = 1'b1;
      tick();
      bus.mm_data_rdy_i = 1'b0;
      tick();
      n_checks++;
      if ({bus.ic_rdy_o, bus.dc_rdy_o, bus.dc_wr_done_o, bus.mm_rd_o, bus.mm_wr_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL idle_rdy_ignored: pulses/req=%b, required 00000",
                  {bus.ic_rdy_o, bus.dc_rdy_o, bus.dc_wr_done_o, bus.mm_rd_o, bus.mm_wr_o});
      end
   endtask

   task automatic test_mid_reset();
      obs_t o;
      bit   seen_rdy;
      do_reset();
      bus.ic_rd_req_i = 1'b1;
      bus.ic_addr_i   = 32'h0000_8000;
      tick();
      rsn = 1'b1;
      #1;
      n_checks++;
      if (bus.mm_rd_o !== 1'b0 || bus.mm_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_abort: mm_rd=%b addr=%h, required 0 / 0", bus.mm_rd_o, bus.mm_addr_o);
      end
      bus.ic_rd_req_i   = 1'b0;
      bus.mm_data_rdy_i = 1'b1;
      seen_rdy = 1'b0;
      tick();
      seen_rdy |= bus.ic_rdy_o;
      bus.mm_data_rdy_i = 1'b0;
      rsn = 1'b0;
      model_reset();
      tick();
      seen_rdy |= bus.ic_rdy_o;
      n_checks++;
      if (seen_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_no_pulse: ic_rdy seen=%b, required 0", seen_rdy);
      end
      bus.ic_rd_req_i = 1'b1;
      bus.ic_addr_i   = 32'h0000_8040;
      void'(model_pick(1'b1, 1'b0, 1'b0));
      serve(2, {4{32'h1234_5678}}, o);
      n_checks++;
      if (o.timeout || o.who !== 0 || o.addr !== 32'h0000_8040 || o.data !== {4{32'h1234_5678}}) begin
         n_fail++;
         $display("FAIL midreset_reissue: who=%0d addr=%h data=%h, required 0 / 00008040",
                  o.who, o.addr, o.data);
      end
   endtask

   task automatic test_random();
      obs_t             o;
      int               exp;
      logic [31:0]      exp_addr, exp_wdata;
      memop_data_type_e exp_wtype;
      logic [127:0]     rdata;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         if (!bus.ic_rd_req_i && $urandom_range(0, 1) == 1) begin
            bus.ic_rd_req_i = 1'b1;  bus.ic_addr_i = $urandom;
         end
         if (!bus.dc_rd_req_i && $urandom_range(0, 1) == 1) begin
            bus.dc_rd_req_i = 1'b1;  bus.dc_addr_i = $urandom;
         end
         if (!bus.dc_wr_req_i && ($urandom_range(0, 1) == 1 ||
                                  !(bus.ic_rd_req_i || bus.dc_rd_req_i))) begin
            bus.dc_wr_req_i  = 1'b1;
            bus.dc_wr_addr_i = $urandom;
            bus.dc_wr_data_i = $urandom;
            bus.dc_wr_type_i = memop_data_type_e'($urandom_range(0, 2));
         end
         exp       = model_pick(bus.ic_rd_req_i, bus.dc_rd_req_i, bus.dc_wr_req_i);
         exp_addr  = (exp == 0) ? bus.ic_addr_i : (exp == 1) ? bus.dc_addr_i : bus.dc_wr_addr_i;
         exp_wdata = bus.dc_wr_data_i;
         exp_wtype = bus.dc_wr_type_i;
         rdata     = {$urandom, $urandom, $urandom, $urandom};
         serve($urandom_range(0, 3), rdata, o);
         n_checks++;
         if (o.timeout || o.who !== exp || o.addr !== exp_addr ||
             o.kind !== ((exp == 2) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL rand_grant_%0d: who=%0d kind=%0d addr=%h timeout=%b, required %0d addr=%h",
                     k, o.who, o.kind, o.addr, o.timeout, exp, exp_addr);
         end
         n_checks++;
         if (o.both_hi || !o.hold_ok || !o.dropped || !o.pulse_ok) begin
            n_fail++;
            $display("FAIL rand_handshake_%0d: both_hi=%b hold=%b dropped=%b pulse_ok=%b, required 0 1 1 1",
                     k, o.both_hi, o.hold_ok, o.dropped, o.pulse_ok);
         end
         n_checks++;
         if (exp == 2 ? (o.wdata !== exp_wdata || o.wtype !== exp_wtype) : (o.data !== rdata)) begin
            n_fail++;
            $display("FAIL rand_payload_%0d: wdata=%h wtype=%0d rdata=%h, required %h %0d %h",
                     k, o.wdata, o.wtype, o.data, exp_wdata, exp_wtype, rdata);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_starvation();
      test_simultaneous();
      test_stability();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
